// File: rtl/sad_best_match.sv
// sad_best_match: scans the SAD result SRAM after the SAD engine finishes and
// reports the smallest result and its index (the best-matching block).
//
// Build option: define SAD_BEST_MATCH_MAX_EN to also track the largest result
// (Max_Sad / Max_Idx). Without it those ports and registers do not exist and
// the minimum path is unchanged.
//
// Read timing: the SRAM returns data one cycle after address+enable, so a
// one-bit valid and an index register follow the address by one cycle and
// the compare happens on the edge after the data appears. The DRAIN state
// exists only to compare the final element after the last read is issued.

module sad_best_match #(
    parameter int N_ENTRIES = 128,
    parameter int CA_WIDTH  = 7,
    parameter int D_WIDTH   = 32
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Go,
    output logic [CA_WIDTH-1:0] C_Addr,
    output logic                C_RW,
    output logic                C_En,
    input  logic [D_WIDTH-1:0]  C_Data,
    output logic [D_WIDTH-1:0]  Min_Sad,
    output logic [CA_WIDTH-1:0] Min_Idx,
`ifdef SAD_BEST_MATCH_MAX_EN
    output logic [D_WIDTH-1:0]  Max_Sad,
    output logic [CA_WIDTH-1:0] Max_Idx,
`endif
    output logic                Done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [CA_WIDTH-1:0] LAST_ADDR = CA_WIDTH'(N_ENTRIES - 1);
    localparam logic [CA_WIDTH-1:0] ADDR_ZERO = {CA_WIDTH{1'b0}};
    localparam logic [CA_WIDTH-1:0] ADDR_ONE  = CA_WIDTH'(1);
    localparam logic [D_WIDTH-1:0]  DATA_ONES = {D_WIDTH{1'b1}};
    localparam logic [D_WIDTH-1:0]  DATA_ZERO = {D_WIDTH{1'b0}};

    logic [1:0]          state_r;
    logic [1:0]          state_nxt_s;
    logic [CA_WIDTH-1:0] addr_nxt_s;
    logic                en_nxt_s;
    logic                done_nxt_s;
    logic                clear_s;

    logic                valid_r;
    logic [CA_WIDTH-1:0] idx_r;
    logic                first_r;
    logic                cmp_en_s;
    logic                take_min_s;
`ifdef SAD_BEST_MATCH_MAX_EN
    logic                take_max_s;
`endif

    // Next-state, next-address and start/clear decisions for the scan FSM
    always_comb begin
        state_nxt_s = state_r;
        addr_nxt_s  = C_Addr;
        en_nxt_s    = C_En;
        done_nxt_s  = Done;
        clear_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                clear_s    = 1'b1;
                addr_nxt_s = ADDR_ZERO;
                done_nxt_s = 1'b0;
                if (Go) begin
                    state_nxt_s = ST_READ;
                    en_nxt_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                    en_nxt_s    = 1'b0;
                end
            end
            ST_READ: begin
                done_nxt_s = 1'b0;
                if (C_Addr == LAST_ADDR) begin
                    // Last address already presented: stop reading, hold address.
                    state_nxt_s = ST_DRAIN;
                    en_nxt_s    = 1'b0;
                    addr_nxt_s  = C_Addr;
                end else begin
                    state_nxt_s = ST_READ;
                    en_nxt_s    = 1'b1;
                    addr_nxt_s  = C_Addr + ADDR_ONE;
                end
            end
            ST_DRAIN: begin
                state_nxt_s = ST_DONE;
                en_nxt_s    = 1'b0;
                done_nxt_s  = 1'b1;
            end
            ST_DONE: begin
                if (Go) begin
                    // Restart behaves exactly like a start from IDLE.
                    state_nxt_s = ST_READ;
                    clear_s     = 1'b1;
                    addr_nxt_s  = ADDR_ZERO;
                    en_nxt_s    = 1'b1;
                    done_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = ST_DONE;
                    en_nxt_s    = 1'b0;
                    done_nxt_s  = 1'b1;
                end
            end
            default: begin
                // Unreachable encoding: fall back to a clean idle.
                state_nxt_s = ST_IDLE;
                clear_s     = 1'b1;
                addr_nxt_s  = ADDR_ZERO;
                en_nxt_s    = 1'b0;
                done_nxt_s  = 1'b0;
            end
        endcase
    end

    // Compare enables: only aligned read data during the scan is considered
    always_comb begin
        cmp_en_s   = valid_r && ((state_r == ST_READ) || (state_r == ST_DRAIN));
        take_min_s = cmp_en_s && (first_r || (C_Data < Min_Sad));
`ifdef SAD_BEST_MATCH_MAX_EN
        take_max_s = cmp_en_s && (first_r || (C_Data > Max_Sad));
`endif
    end

    // FSM state, SRAM address/enable and Done flag registers
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_r <= ST_IDLE;
            C_Addr  <= ADDR_ZERO;
            C_En    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            C_Addr  <= addr_nxt_s;
            C_En    <= en_nxt_s;
            Done    <= done_nxt_s;
        end
    end

    // SRAM direction is read-only for this block
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            C_RW <= 1'b0;
        end else begin
            C_RW <= 1'b0;
        end
    end

    // One-cycle valid/index pipe aligning the address with returned data
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            valid_r <= 1'b0;
            idx_r   <= ADDR_ZERO;
        end else begin
            valid_r <= C_En;
            idx_r   <= C_Addr;
        end
    end

    // First-element flag: forces the first compared element to load
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            first_r <= 1'b1;
        end else if (clear_s) begin
            first_r <= 1'b1;
        end else if (cmp_en_s) begin
            first_r <= 1'b0;
        end else begin
            first_r <= first_r;
        end
    end

    // Running minimum; strict less-than so ties keep the lowest index
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Min_Sad <= DATA_ONES;
            Min_Idx <= ADDR_ZERO;
        end else if (clear_s) begin
            Min_Sad <= DATA_ONES;
            Min_Idx <= ADDR_ZERO;
        end else if (take_min_s) begin
            Min_Sad <= C_Data;
            Min_Idx <= idx_r;
        end else begin
            Min_Sad <= Min_Sad;
            Min_Idx <= Min_Idx;
        end
    end

`ifdef SAD_BEST_MATCH_MAX_EN
    // Running maximum; strict greater-than so ties keep the lowest index
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Max_Sad <= DATA_ZERO;
            Max_Idx <= ADDR_ZERO;
        end else if (clear_s) begin
            Max_Sad <= DATA_ZERO;
            Max_Idx <= ADDR_ZERO;
        end else if (take_max_s) begin
            Max_Sad <= C_Data;
            Max_Idx <= idx_r;
        end else begin
            Max_Sad <= Max_Sad;
            Max_Idx <= Max_Idx;
        end
    end
`else
    // Zero constant is only consumed by the optional maximum path.
    logic unused_zero_s;
    assign unused_zero_s = ^DATA_ZERO;
`endif

endmodule

// File: doc/sad_best_match.md
Name: sad_best_match

Overview:
- Downstream consumer of the SAD engine's result SRAM.
- After SAD asserts Done, this block is started with Go. It streams all N_ENTRIES 32-bit SAD results out of Sram_Result and reports the minimum value and its index (best-match block).
- It shares the result SRAM read port with SAD; the two blocks are never active simultaneously.

Parameters:
- N_ENTRIES, 128, number of SAD results to scan.
- CA_WIDTH, 7, result SRAM address width; must satisfy 2**CA_WIDTH >= N_ENTRIES.
- D_WIDTH, 32, SAD result data width.

Ports:
- Clk  in  1  system clock, rising-edge active.
- Rst  in  1  reset, asynchronous, active-low.
- Go  in  1  start request; sampled only in IDLE or DONE.
- C_Addr  out  CA_WIDTH  result SRAM address.
- C_RW  out  1  SRAM direction; held 0 (read) at all times.
- C_En  out  1  SRAM enable; 1 only while issuing reads.
- C_Data  in  D_WIDTH  SRAM read data, valid the cycle after address+enable.
- Min_Sad  out  D_WIDTH  smallest SAD found.
- Min_Idx  out  CA_WIDTH  index of Min_Sad.
- Done  out  1  result valid; level signal.

Behaviour:
- Reset (Rst=0, asynchronous) clears:
  - state to IDLE
  - C_Addr=0, C_En=0, C_RW=0
  - Min_Sad=all ones, Min_Idx=0, Done=0
  - internal valid pipe=0, first flag=1
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - Go=1 at edge E0 -> READ.
  - C_Addr<=0, Min_Sad<=all ones, Min_Idx<=0, first<=1.
- READ:
  - C_En=1, C_RW=0. C_Addr increments by 1 each edge.
  - When C_Addr==N_ENTRIES-1 is presented, the next edge moves to DRAIN; C_Addr holds and C_En drops.
- Data pipeline:
  - A one-bit valid plus an index register delays the address by one cycle to align it with C_Data.
  - At the edge after valid data (index k) is present, the comparison is made.
- Compare rule:
  - If first=1, or C_Data < Min_Sad (unsigned, strictly less): Min_Sad<=C_Data, Min_Idx<=k, first<=0.
  - Ties keep the lowest index.
- DRAIN: one cycle that compares the last element (index N_ENTRIES-1), then -> DONE.
- DONE:
  - Done=1; Min_Sad and Min_Idx are stable.
  - Go=1 -> clear Done, restart exactly as from IDLE. Go=0 -> stay.
- Latency:
  - Go sampled at E0 -> Done=1 after edge E(N_ENTRIES+1), i.e. E129 for the default.
  - C_En is high for exactly N_ENTRIES cycles.
- Go while in READ or DRAIN: ignored; no restart, no counter disturbance.
- Go held high continuously: runs back-to-back. Done is high for one cycle between runs, and the new run's scan begins from IDLE-equivalent clearing.
- Rst asserted mid-scan: immediate return to reset values. The SRAM is not accessed until a new Go.
- All-ones data: Min_Sad=all ones, and Min_Idx=0 (forced by the first-element load).
- C_Addr never exceeds N_ENTRIES-1; no wrap-around.

Optional Feature:
- Macro: SAD_BEST_MATCH_MAX_EN.
- Defined:
  - Adds output ports Max_Sad (D_WIDTH) and Max_Idx (CA_WIDTH).
  - Reset and restart values are 0 and 0.
  - Update rule: first=1, or C_Data > Max_Sad (strictly greater); ties keep the lowest index.
  - Valid under the same Done.
- Undefined: the ports and registers do not exist. The min-path behaviour and latency are identical in both builds.

Test Plan:
- Memory[i]=i+5, Go pulse -> Done after 129 edges; Min_Sad=5, Min_Idx=0; C_En high exactly 128 cycles; C_RW always 0.
- Memory[i]=200-i except Memory[127]=0 -> Min_Sad=0, Min_Idx=127 (checks the DRAIN compare).
- All entries 0x10; Memory[40]=Memory[90]=0x3 -> Min_Sad=0x3, Min_Idx=40 (tie keeps lowest index).
- All entries 0xFFFFFFFF -> Min_Sad=0xFFFFFFFF, Min_Idx=0.
- Go re-pulsed at cycle 50 of READ, then Rst low at cycle 70:
  - Go causes no restart.
  - Rst immediately forces Done=0, C_En=0, Min_Sad=all ones.
  - A fresh Go then completes a normal scan with correct results.
- SAD_BEST_MATCH_MAX_EN build, Memory[i]=i*3, Memory[64]=0xFFFF0000 -> Max_Sad=0xFFFF0000, Max_Idx=64, Min_Sad=0, Min_Idx=0.
